rx_payload_store_ctrl: RTL and testbench

//  Consumer end of the TCP slow path "RX copy to buffers" interface. Accepts one
//  per-packet descriptor (flowid, accept flag, smol payload entry). For each

---
 rtl/rx_payload_store_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_rx_payload_store_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_payload_store_ctrl.sv
// rx_payload_store_ctrl
//   Consumer end of the TCP slow-path "RX copy to buffers" interface. Takes one
//   packet descriptor at a time, reads the flow's RX commit pointer, issues one
//   or two copy requests to the payload mover (two when the payload straddles
//   the end of the circular flow buffer), writes back the advanced commit
//   pointer and finally releases the smol payload buffer.
//
// Ports
//   clk, rst                          clock, synchronous active-high reset
//   tcp_rx_dst_*, dst_tcp_rx_hdr_rdy  descriptor in {flowid, accept, {addr, len}}
//   store_buf_commit_ptr_rd_*         commit pointer read request / response
//   store_buf_commit_ptr_wr_*         commit pointer write
//   store_buf_copy_req_*              copy request to payload mover
//   copy_store_buf_done_val/_rdy      copy completion, one pulse per request
//   store_buf_free_*                  smol payload buffer release
//   stat_pkts_committed/_dropped      saturating packet counters
//
// State table
//   state      | meaning
//   ST_IDLE    | waiting for a descriptor
//   ST_CP_RD   | commit pointer read request outstanding
//   ST_CP_RESP | waiting for commit pointer read data
//   ST_COPY0   | first (possibly only) copy request
//   ST_WAIT0   | waiting for first copy done
//   ST_COPY1   | second copy, wrapped to buffer offset 0
//   ST_WAIT1   | waiting for second copy done
//   ST_CP_WR   | writing advanced commit pointer
//   ST_FREE    | releasing the smol payload buffer
module rx_payload_store_ctrl #(
  parameter int FLOWID_W             = 8,
  parameter int RX_PAYLOAD_PTR_W     = 14,
  parameter int PAYLOAD_ENTRY_ADDR_W = 16,
  parameter int PAYLOAD_ENTRY_LEN_W  = 16,
  parameter int STAT_W               = 32,
  localparam int SMOL_PAYLOAD_BUF_STRUCT_W = PAYLOAD_ENTRY_ADDR_W + PAYLOAD_ENTRY_LEN_W
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 tcp_rx_dst_hdr_val,
  input  logic [FLOWID_W-1:0]                  tcp_rx_dst_flowid,
  input  logic                                 tcp_rx_dst_pkt_accept,
  input  logic [SMOL_PAYLOAD_BUF_STRUCT_W-1:0] tcp_rx_dst_payload_entry,
  output logic                                 dst_tcp_rx_hdr_rdy,

  output logic                                 store_buf_commit_ptr_rd_req_val,
  output logic [FLOWID_W-1:0]                  store_buf_commit_ptr_rd_req_addr,
  input  logic                                 commit_ptr_store_buf_rd_req_rdy,
  input  logic                                 commit_ptr_store_buf_rd_resp_val,
  input  logic [RX_PAYLOAD_PTR_W:0]            commit_ptr_store_buf_rd_resp_data,
  output logic                                 store_buf_commit_ptr_rd_resp_rdy,

  output logic                                 store_buf_commit_ptr_wr_req_val,
  output logic [FLOWID_W-1:0]                  store_buf_commit_ptr_wr_req_addr,
  output logic [RX_PAYLOAD_PTR_W:0]            store_buf_commit_ptr_wr_req_data,
  input  logic                                 commit_ptr_store_buf_wr_req_rdy,

  output logic                                 store_buf_copy_req_val,
  output logic [PAYLOAD_ENTRY_ADDR_W-1:0]      store_buf_copy_req_src_addr,
  output logic [RX_PAYLOAD_PTR_W-1:0]          store_buf_copy_req_dst_addr,
  output logic [FLOWID_W-1:0]                  store_buf_copy_req_flowid,
  output logic [PAYLOAD_ENTRY_LEN_W-1:0]       store_buf_copy_req_len,
  input  logic                                 copy_store_buf_req_rdy,

  input  logic                                 copy_store_buf_done_val,
  output logic                                 store_buf_copy_done_rdy,

  output logic                                 store_buf_free_val,
  output logic [PAYLOAD_ENTRY_ADDR_W-1:0]      store_buf_free_addr,
  input  logic                                 free_store_buf_rdy,

  output logic [STAT_W-1:0]                    stat_pkts_committed,
  output logic [STAT_W-1:0]                    stat_pkts_dropped
);

  localparam int PTR_W  = RX_PAYLOAD_PTR_W;
  localparam int ADDR_W = PAYLOAD_ENTRY_ADDR_W;
  localparam int LEN_W  = PAYLOAD_ENTRY_LEN_W;
  // Wide enough to hold both a length and the room-to-end value (up to 2^PTR_W).
  localparam int CALC_W = ((LEN_W > PTR_W + 1) ? LEN_W : PTR_W + 1) + 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CP_RD,
    ST_CP_RESP,
    ST_COPY0,
    ST_WAIT0,
    ST_COPY1,
    ST_WAIT1,
    ST_CP_WR,
    ST_FREE
  } state_t;

  state_t              state_q,     state_d;
  logic [FLOWID_W-1:0] flowid_q,    flowid_d;
  logic                accept_q,    accept_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [LEN_W-1:0]    len_q,       len_d;
  logic [PTR_W:0]      ptr_q,       ptr_d;
  logic [LEN_W-1:0]    first_q,     first_d;
  logic [STAT_W-1:0]   committed_q, committed_d;
  logic [STAT_W-1:0]   dropped_q,   dropped_d;

  logic [ADDR_W-1:0]   hdr_addr;
  logic [LEN_W-1:0]    hdr_len;
  logic [PTR_W-1:0]    resp_off;
  logic [CALC_W-1:0]   room_w;
  logic [LEN_W-1:0]    first_calc;
  logic [PTR_W:0]      new_ptr;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  assign hdr_addr = tcp_rx_dst_payload_entry[SMOL_PAYLOAD_BUF_STRUCT_W-1:LEN_W];
  assign hdr_len  = tcp_rx_dst_payload_entry[LEN_W-1:0];

  // Bytes left before the end of the circular buffer, from the pointer being
  // returned right now; the first copy is clipped to this.
  assign resp_off   = commit_ptr_store_buf_rd_resp_data[PTR_W-1:0];
  assign room_w     = (CALC_W'(1) << PTR_W) - CALC_W'(resp_off);
  assign first_calc = (CALC_W'(len_q) <= room_w) ? len_q : room_w[LEN_W-1:0];

  // Pointer keeps one extra wrap bit; the natural modulo of this width toggles
  // it whenever the payload crosses the buffer end.
  assign new_ptr = ptr_q + (PTR_W + 1)'(len_q);

  always_comb begin
    state_d     = state_q;
    flowid_d    = flowid_q;
    accept_d    = accept_q;
    addr_d      = addr_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    committed_d = committed_q;
    dropped_d   = dropped_q;

    dst_tcp_rx_hdr_rdy               = 1'b0;
    store_buf_commit_ptr_rd_req_val  = 1'b0;
    store_buf_commit_ptr_rd_req_addr = '0;
    store_buf_commit_ptr_rd_resp_rdy = 1'b0;
    store_buf_commit_ptr_wr_req_val  = 1'b0;
    store_buf_commit_ptr_wr_req_addr = '0;
    store_buf_commit_ptr_wr_req_data = '0;
    store_buf_copy_req_val           = 1'b0;
    store_buf_copy_req_src_addr      = '0;
    store_buf_copy_req_dst_addr      = '0;
    store_buf_copy_req_flowid        = '0;
    store_buf_copy_req_len           = '0;
    store_buf_copy_done_rdy          = 1'b0;
    store_buf_free_val               = 1'b0;
    store_buf_free_addr              = '0;

    case (state_q)
      ST_IDLE: begin
        dst_tcp_rx_hdr_rdy = 1'b1;
        if (tcp_rx_dst_hdr_val) begin
          flowid_d = tcp_rx_dst_flowid;
          accept_d = tcp_rx_dst_pkt_accept;
          addr_d   = hdr_addr;
          len_d    = hdr_len;
          if (hdr_len == '0) begin
            state_d = ST_IDLE;
          end else if (!tcp_rx_dst_pkt_accept) begin
            dropped_d = sat_inc(dropped_q);
            state_d   = ST_FREE;
          end else begin
            state_d = ST_CP_RD;
          end
        end
      end

      ST_CP_RD: begin
        store_buf_commit_ptr_rd_req_val  = 1'b1;
        store_buf_commit_ptr_rd_req_addr = flowid_q;
        if (commit_ptr_store_buf_rd_req_rdy) state_d = ST_CP_RESP;
      end

      ST_CP_RESP: begin
        store_buf_commit_ptr_rd_resp_rdy = 1'b1;
        if (commit_ptr_store_buf_rd_resp_val) begin
          ptr_d   = commit_ptr_store_buf_rd_resp_data;
          first_d = first_calc;
          state_d = ST_COPY0;
        end
      end

      ST_COPY0: begin
        store_buf_copy_req_val      = 1'b1;
        store_buf_copy_req_src_addr = addr_q;
        store_buf_copy_req_dst_addr = ptr_q[PTR_W-1:0];
        store_buf_copy_req_flowid   = flowid_q;
        store_buf_copy_req_len      = first_q;
        if (copy_store_buf_req_rdy) state_d = ST_WAIT0;
      end

      ST_WAIT0: begin
        store_buf_copy_done_rdy = 1'b1;
        if (copy_store_buf_done_val) begin
          state_d = (first_q == len_q) ? ST_CP_WR : ST_COPY1;
        end
      end

      ST_COPY1: begin
        store_buf_copy_req_val      = 1'b1;
        store_buf_copy_req_src_addr = addr_q + ADDR_W'(first_q);
        store_buf_copy_req_dst_addr = '0;
        store_buf_copy_req_flowid   = flowid_q;
        store_buf_copy_req_len      = len_q - first_q;
        if (copy_store_buf_req_rdy) state_d = ST_WAIT1;
      end

      ST_WAIT1: begin
        store_buf_copy_done_rdy = 1'b1;
        if (copy_store_buf_done_val) state_d = ST_CP_WR;
      end

      ST_CP_WR: begin
        store_buf_commit_ptr_wr_req_val  = 1'b1;
        store_buf_commit_ptr_wr_req_addr = flowid_q;
        store_buf_commit_ptr_wr_req_data = new_ptr;
        if (commit_ptr_store_buf_wr_req_rdy) state_d = ST_FREE;
      end

      ST_FREE: begin
        store_buf_free_val  = 1'b1;
        store_buf_free_addr = addr_q;
        if (free_store_buf_rdy) begin
          if (accept_q) committed_d = sat_inc(committed_q);
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flowid_q    <= '0;
      accept_q    <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      ptr_q       <= '0;
      first_q     <= '0;
      committed_q <= '0;
      dropped_q   <= '0;
    end else begin
      state_q     <= state_d;
      flowid_q    <= flowid_d;
      accept_q    <= accept_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      committed_q <= committed_d;
      dropped_q   <= dropped_d;
    end
  end

  assign stat_pkts_committed = committed_q;
  assign stat_pkts_dropped   = dropped_q;

  // A completion with no copy outstanding is ignored by the FSM; flag it here.
`ifndef SYNTHESIS
  done_outside_wait: assert property (@(posedge clk) disable iff (rst)
    copy_store_buf_done_val |-> (state_q == ST_WAIT0 || state_q == ST_WAIT1));
`endif

endmodule

// File: tb/tb_rx_payload_store_ctrl.sv
module tb_rx_payload_store_ctrl;

  localparam int FW = 8;
  localparam int W  = 14;
  localparam int PW = W + 1;
  localparam int AW = 16;
  localparam int LW = 16;
  localparam int SW = 4;
  localparam int SAT = (1 << SW) - 1;

  typedef struct packed {logic [FW-1:0] flow; logic acc; logic [AW-1:0] addr; logic [LW-1:0] len;} desc_t;
  typedef struct packed {logic [AW-1:0] src; logic [W-1:0] dst; logic [FW-1:0] flow; logic [LW-1:0] len;} copy_t;
  typedef struct packed {logic [FW-1:0] flow; logic [PW-1:0] data;} wr_t;
  typedef struct packed {logic [AW-1:0] addr; logic acc;} free_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic hdr_val, hdr_accept, hdr_rdy;
  logic [FW-1:0] hdr_flowid;
  logic [AW+LW-1:0] hdr_entry;
  logic rd_val, rd_rdy, resp_val, resp_rdy;
  logic [FW-1:0] rd_addr;
  logic [PW-1:0] resp_data;
  logic wr_val, wr_rdy;
  logic [FW-1:0] wr_addr;
  logic [PW-1:0] wr_data;
  logic copy_val, copy_rdy;
  logic [AW-1:0] copy_src;
  logic [W-1:0] copy_dst;
  logic [FW-1:0] copy_flow;
  logic [LW-1:0] copy_len;
  logic done_val, done_rdy;
  logic free_val, free_rdy;
  logic [AW-1:0] free_addr;
  logic [SW-1:0] stat_committed, stat_dropped;

  rx_payload_store_ctrl #(
    .FLOWID_W(FW), .RX_PAYLOAD_PTR_W(W), .PAYLOAD_ENTRY_ADDR_W(AW),
    .PAYLOAD_ENTRY_LEN_W(LW), .STAT_W(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .tcp_rx_dst_hdr_val(hdr_val), .tcp_rx_dst_flowid(hdr_flowid),
    .tcp_rx_dst_pkt_accept(hdr_accept), .tcp_rx_dst_payload_entry(hdr_entry),
    .dst_tcp_rx_hdr_rdy(hdr_rdy),
    .store_buf_commit_ptr_rd_req_val(rd_val), .store_buf_commit_ptr_rd_req_addr(rd_addr),
    .commit_ptr_store_buf_rd_req_rdy(rd_rdy),
    .commit_ptr_store_buf_rd_resp_val(resp_val), .commit_ptr_store_buf_rd_resp_data(resp_data),
    .store_buf_commit_ptr_rd_resp_rdy(resp_rdy),
    .store_buf_commit_ptr_wr_req_val(wr_val), .store_buf_commit_ptr_wr_req_addr(wr_addr),
    .store_buf_commit_ptr_wr_req_data(wr_data), .commit_ptr_store_buf_wr_req_rdy(wr_rdy),
    .store_buf_copy_req_val(copy_val), .store_buf_copy_req_src_addr(copy_src),
    .store_buf_copy_req_dst_addr(copy_dst), .store_buf_copy_req_flowid(copy_flow),
    .store_buf_copy_req_len(copy_len), .copy_store_buf_req_rdy(copy_rdy),
    .copy_store_buf_done_val(done_val), .store_buf_copy_done_rdy(done_rdy),
    .store_buf_free_val(free_val), .store_buf_free_addr(free_addr),
    .free_store_buf_rdy(free_rdy),
    .stat_pkts_committed(stat_committed), .stat_pkts_dropped(stat_dropped)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Environment: commit pointer memory seen by the DUT, and the model's view.
  logic [PW-1:0] mem  [0:(1<<FW)-1];
  logic [PW-1:0] mref [0:(1<<FW)-1];

  desc_t pending_desc[$];
  logic [FW-1:0] exp_rd[$];
  copy_t exp_copy[$];
  wr_t   exp_wr[$];
  free_t exp_free[$];
  int n_committed = 0;
  int n_dropped = 0;

  bit bp = 1'b0;
  bit rst_drv = 1'b1;
  bit resp_pending = 1'b0;
  int resp_delay = 0;
  logic [PW-1:0] resp_word = '0;
  bit done_pending = 1'b0;
  int done_delay = 0;
  int copy_seen = 0;
  int hold_at = 32'h7fffffff;
  bit chk_rdy_next = 1'b0;
  bit lat_meas = 1'b0;
  bit lat_arm = 1'b0;
  int lat = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Reference: what the consumer must do for one accepted descriptor.
  task automatic model_accept(input desc_t d);
    int p, off, room, np;
    if (d.len == 0) return;
    if (!d.acc) begin
      exp_free.push_back('{addr: d.addr, acc: 1'b0});
      n_dropped++;
      return;
    end
    p    = int'(mref[d.flow]);
    off  = p % (1 << W);
    room = (1 << W) - off;
    exp_rd.push_back(d.flow);
    if (int'(d.len) <= room) begin
      exp_copy.push_back('{src: d.addr, dst: W'(off), flow: d.flow, len: d.len});
    end else begin
      exp_copy.push_back('{src: d.addr, dst: W'(off), flow: d.flow, len: LW'(room)});
      exp_copy.push_back('{src: AW'(int'(d.addr) + room), dst: W'(0), flow: d.flow,
                           len: LW'(int'(d.len) - room)});
    end
    np = (p + int'(d.len)) % (1 << PW);
    exp_wr.push_back('{flow: d.flow, data: PW'(np)});
    mref[d.flow] = PW'(np);
    exp_free.push_back('{addr: d.addr, acc: 1'b1});
  endtask

  // One cycle: inputs are driven at the falling edge, and the handshakes they
  // produce at the next rising edge are scored right away.
  task automatic step();
    copy_t c;
    wr_t w;
    free_t f;
    desc_t d;
    @(negedge clk);
    if (chk_rdy_next) begin
      chk("len0_rdy_next", hdr_rdy, 1);
      chk_rdy_next = 1'b0;
    end
    if (lat_arm) begin
      lat++;
      if (hdr_rdy) begin
        chk("latency", lat, 7);
        lat_arm = 1'b0;
      end
    end

    rst      = rst_drv;
    rd_rdy   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    wr_rdy   = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    copy_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    free_rdy = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (resp_pending && resp_delay > 0) resp_delay--;
    resp_val  = resp_pending && resp_delay == 0;
    resp_data = resp_val ? resp_word : PW'($urandom);
    if (done_pending && done_delay > 0) done_delay--;
    done_val = done_pending && done_delay == 0 && copy_seen < hold_at;
    if (pending_desc.size() > 0 && (!bp || $urandom_range(0, 2) != 0)) begin
      d = pending_desc[0];
      hdr_val = 1'b1; hdr_flowid = d.flow; hdr_accept = d.acc; hdr_entry = {d.addr, d.len};
    end else begin
      hdr_val = 1'b0; hdr_flowid = FW'($urandom); hdr_accept = 1'($urandom);
      hdr_entry = (AW+LW)'($urandom);
    end

    if (!rst) begin
      if (hdr_val && hdr_rdy) begin
        d = pending_desc.pop_front();
        model_accept(d);
        if (d.len == 0) chk_rdy_next = 1'b1;
        if (lat_meas) begin lat_arm = 1'b1; lat = 0; end
      end
      if (rd_val && rd_rdy) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_flow", rd_addr, exp_rd.pop_front());
        resp_word    = mem[rd_addr];
        resp_pending = 1'b1;
        resp_delay   = bp ? $urandom_range(0, 3) : 0;
      end
      if (resp_val && resp_rdy) resp_pending = 1'b0;
      if (copy_val && copy_rdy) begin
        copy_seen++;
        if (exp_copy.size() == 0) chk("copy_unexpected", 1, 0);
        else begin
          c = exp_copy.pop_front();
          chk("copy_src", copy_src, c.src);
          chk("copy_dst", copy_dst, c.dst);
          chk("copy_flow", copy_flow, c.flow);
          chk("copy_len", copy_len, c.len);
        end
        done_pending = 1'b1;
        done_delay   = bp ? $urandom_range(0, 4) : 0;
      end
      if (done_val && done_rdy) done_pending = 1'b0;
      if (wr_val && wr_rdy) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_flow", wr_addr, w.flow);
          chk("wr_data", wr_data, w.data);
        end
        mem[wr_addr] = wr_data;
      end
      if (free_val && free_rdy) begin
        if (exp_free.size() == 0) chk("free_unexpected", 1, 0);
        else begin
          f = exp_free.pop_front();
          chk("free_addr", free_addr, f.addr);
          if (f.acc) n_committed++;
        end
      end
    end
  endtask

  function automatic bit idle();
    return pending_desc.size() == 0 && exp_rd.size() == 0 && exp_copy.size() == 0 &&
           exp_wr.size() == 0 && exp_free.size() == 0 && !resp_pending && !done_pending &&
           hdr_rdy;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    do begin
      step();
      n++;
    end while (!idle() && n < budget);
    if (!idle()) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_stats();
    chk("stat_committed", stat_committed, sat(n_committed));
    chk("stat_dropped", stat_dropped, sat(n_dropped));
  endtask

  task automatic send(input int flow, input bit acc, input int addr, input int len);
    pending_desc.push_back('{flow: FW'(flow), acc: acc, addr: AW'(addr), len: LW'(len)});
  endtask

  task automatic preset(input int flow, input int p);
    mem[flow]  = PW'(p);
    mref[flow] = PW'(p);
  endtask

  initial begin
    logic [PW-1:0] saved;
    int n;
    for (int i = 0; i < (1 << FW); i++) begin mem[i] = '0; mref[i] = '0; end
    hdr_val = 0; hdr_flowid = 0; hdr_accept = 0; hdr_entry = 0;
    rd_rdy = 0; resp_val = 0; resp_data = 0; wr_rdy = 0; copy_rdy = 0;
    done_val = 0; free_rdy = 0; rst = 1;

    rst_drv = 1'b1;
    repeat (3) step();
    chk("rst_hdr_rdy", hdr_rdy, 1);
    chk("rst_vals", {rd_val, resp_rdy, wr_val, copy_val, done_rdy, free_val}, 0);
    chk("rst_data", |{rd_addr, wr_addr, wr_data, copy_src, copy_dst, copy_flow, copy_len, free_addr}, 0);
    chk_stats();
    rst_drv = 1'b0;
    step();

    // Single copy, plus the no-backpressure latency.
    preset(3, 'h0100);
    lat_meas = 1'b1;
    send(3, 1, 'h20, 64);
    drain(100);
    lat_meas = 1'b0;
    chk("t1_ptr", mem[3], 'h0140);
    chk("t1_committed", stat_committed, 1);

    // Crossing the buffer end: two copies, wrap bit set.
    preset(4, 'h3FF0);
    send(4, 1, 'h40, 48);
    drain(100);
    chk("t2_ptr", mem[4], 'h4020);

    // Ending exactly on the buffer end: one copy, wrap bit toggles back.
    preset(6, 'h7FC0);
    send(6, 1, 'h80, 64);
    drain(100);
    chk("t3_ptr", mem[6], 'h0000);
    chk_stats();

    // Dropped payload, then empty payload.
    send(2, 0, 'h7, 100);
    drain(100);
    chk("t4_dropped", stat_dropped, 1);
    send(2, 1, 'h9, 0);
    drain(100);
    chk_stats();

    // Random traffic with backpressure on every ready and random done delay.
    for (int i = 0; i < 8; i++) preset(i, $urandom_range(0, (1 << PW) - 1));
    bp = 1'b1;
    for (int i = 0; i < 500; i++) begin
      desc_t d;
      d.flow = FW'($urandom_range(0, 7));
      d.acc  = ($urandom_range(0, 9) != 0);
      d.addr = AW'($urandom);
      d.len  = ($urandom_range(0, 9) == 0) ? LW'(0) : LW'($urandom_range(1, 3000));
      pending_desc.push_back(d);
    end
    drain(40000);
    for (int i = 0; i < 8; i++) chk("rand_ptr", mem[i], mref[i]);
    chk_stats();
    bp = 1'b0;

    // Reset while waiting for the second copy completion.
    preset(9, 'h3FF0);
    saved   = mref[9];
    hold_at = copy_seen + 2;
    send(9, 1, 'h40, 48);
    n = 0;
    while (copy_seen < hold_at && n < 100) begin step(); n++; end
    chk("rst_reach_wait1", copy_seen >= hold_at, 1);
    repeat (3) step();
    rst_drv = 1'b1;
    exp_rd.delete(); exp_copy.delete(); exp_wr.delete(); exp_free.delete();
    done_pending = 1'b0; resp_pending = 1'b0;
    mref[9] = saved;
    n_committed = 0; n_dropped = 0;
    hold_at = 32'h7fffffff;
    repeat (2) step();
    rst_drv = 1'b0;
    repeat (6) step();
    chk("rst_mid_ptr", mem[9], 'h3FF0);
    chk("rst_mid_rdy", hdr_rdy, 1);
    chk_stats();
    send(9, 1, 'h40, 48);
    drain(100);
    chk("rst_after_ptr", mem[9], 'h4020);
    chk_stats();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
